// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, GF(2^8) helpers and S-box functions
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_e;

  // Byte 0 of a 128-bit block lives in [127:120].
  function automatic int byte_lsb(input int n);
    return 120 - 8 * n;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/byte_sub.sv
// rtl/byte_sub.sv - single-byte forward S-box for the key schedule
module byte_sub
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox(a);
endmodule

// File: rtl/inv_byte_sub.sv
// rtl/inv_byte_sub.sv - single-byte inverse S-box
module inv_byte_sub
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = inv_sbox(a);
endmodule

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES-128 decryption, one round per clock
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit RESET_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipherText,
  input  logic [127:0] cipherKey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plainText,
  output logic         busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_inv_cipher supports only NR=10");
  end

  fsm_e         fsm, fsm_nxt;
  logic [3:0]   cnt;
  logic [127:0] blk, key;
  logic [31:0]  sw_in, rot, sub_word, k_step;
  logic [7:0]   rc;
  logic [127:0] fwd_key, rev_key, shifted, subbed, added, mixed, round_out;

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == KEYEXP) || (fsm == ROUND);

  // The SubWord instances are shared: forward schedule feeds w3, reverse feeds k3^k2.
  assign sw_in = (fsm == ROUND) ? (key[31:0] ^ key[63:32]) : key[31:0];
  assign rot   = {sw_in[23:0], sw_in[31:24]};
  assign rc    = rcon((fsm == ROUND) ? cnt + 4'd1 : cnt);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
    byte_sub u_sb (.a(rot[8*gi +: 8]), .y(sub_word[8*gi +: 8]));
  end

  assign k_step = sub_word ^ {rc, 24'h000000};

  always_comb begin
    fwd_key          = '0;
    fwd_key[127:96]  = key[127:96] ^ k_step;
    fwd_key[95:64]   = key[95:64] ^ fwd_key[127:96];
    fwd_key[63:32]   = key[63:32] ^ fwd_key[95:64];
    fwd_key[31:0]    = key[31:0] ^ fwd_key[63:32];
    rev_key[31:0]    = key[31:0] ^ key[63:32];
    rev_key[63:32]   = key[63:32] ^ key[95:64];
    rev_key[95:64]   = key[95:64] ^ key[127:96];
    rev_key[127:96]  = key[127:96] ^ k_step;
  end

  always_comb begin
    shifted = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        shifted[byte_lsb(r + 4*c) +: 8] = blk[byte_lsb(r + 4*((c - r + 4) % 4)) +: 8];
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
    inv_byte_sub u_isb (.a(shifted[8*gi +: 8]), .y(subbed[8*gi +: 8]));
  end

  assign added = subbed ^ rev_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
  end

  assign round_out = (cnt == 4'd0) ? added : mixed;

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:   if (in_valid)      fsm_nxt = KEYEXP;
      KEYEXP: if (cnt == 4'd10)  fsm_nxt = ROUND;
      ROUND:  if (cnt == 4'd0)   fsm_nxt = DONE;
      DONE:   if (out_ready)     fsm_nxt = IDLE;
    endcase
  end

  // Datapath is intentionally unreset; the FSM alone decides what is meaningful.
  always_ff @(posedge clk) begin
    unique case (fsm)
      IDLE: if (in_valid) begin
        blk <= cipherText;
        key <= cipherKey;
        cnt <= 4'd1;
      end
      KEYEXP: begin
        key <= fwd_key;
        if (cnt == 4'd10) begin
          blk <= blk ^ fwd_key;
          cnt <= 4'd9;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      ROUND: begin
        key <= rev_key;
        blk <= round_out;
        cnt <= cnt - 4'd1;
      end
      DONE: ;
    endcase
  end

  if (RESET_OUT) begin : g_out_rst
    always_ff @(posedge clk) begin
      if (reset)                                plainText <= '0;
      else if (fsm == ROUND && cnt == 4'd0)     plainText <= round_out;
    end
  end else begin : g_out_norst
    always_ff @(posedge clk) begin
      if (fsm == ROUND && cnt == 4'd0) plainText <= round_out;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - self-checking bench for aes_inv_cipher
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipherText;
  logic [127:0] cipherKey;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plainText;
  logic         busy;

  int checks = 0;
  int failures = 0;

  aes_inv_cipher dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .cipherText(cipherText), .cipherKey(cipherKey),
    .out_valid(out_valid), .out_ready(out_ready),
    .plainText(plainText), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Reference model: textbook AES-128 inverse cipher over byte arrays.
  logic [7:0]  sb [256];
  logic [7:0]  isb[256];
  logic [31:0] w  [44];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic void build_tables();
    logic [7:0] inv, s, v;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) begin
        v = 8'((inv << k) | (inv >> (8 - k)));
        s ^= v;
      end
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rcm;
    rcm = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcm, 24'h0};
        rcm = gm(rcm, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   s[16], t[16], a0, a1, a2, a3;
    logic [31:0]  kw;
    logic [127:0] res;
    expand(k);
    for (int i = 0; i < 16; i++) begin
      kw = w[40 + i/4];
      s[i] = ct[127 - 8*i -: 8] ^ kw[31 - 8*(i%4) -: 8];
    end
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*((c + r) % 4)] = s[r + 4*c];
      for (int i = 0; i < 16; i++) begin
        kw = w[4*rnd + i/4];
        s[i] = isb[t[i]] ^ kw[31 - 8*(i%4) -: 8];
      end
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
          s[4*c+1] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
          s[4*c+2] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
          s[4*c+3] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block and steps past its accept edge; returns in cycle 1.
  task automatic send(input logic [127:0] k, input logic [127:0] ct);
    in_valid   = 1'b1;
    cipherKey  = k;
    cipherText = ct;
    tick();
  endtask

  task automatic wait_valid(input int start, output int lat, output int busy_bad);
    int cyc;
    cyc = start;
    busy_bad = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      cyc++;
    end
    lat = cyc;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    int lat, bb, outs, idx, t, ov_seen;
    int acc_cyc[3];
    logic [127:0] k2, c2, kk[3], cc[3], ee[3];
    logic acc;

    build_tables();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cipherText = '0; cipherKey = '0;
    tick(); tick();
    reset = 1'b0;

    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_plaintext", plainText, 128'd0);
    chk("model_c1", model_dec(C1_KEY, C1_CT), C1_PT);

    // FIPS-197 C.1
    send(C1_KEY, C1_CT);
    in_valid = 1'b0;
    wait_valid(1, lat, bb);
    chk("c1_latency", 128'(lat), 128'd21);
    chk("c1_busy_cycles", 128'(bb), 128'd0);
    chk("c1_busy_done", 128'(busy), 128'd0);
    chk("c1_plaintext", plainText, C1_PT);
    tick();
    chk("c1_released", 128'(out_valid), 128'd0);
    chk("c1_in_ready_after", 128'(in_ready), 128'd1);

    // All-zero key
    send('0, Z_CT);
    in_valid = 1'b0;
    repeat (10) tick();
    expand('0);
    chk("zero_rk10", dut.key, {w[40], w[41], w[42], w[43]});
    wait_valid(11, lat, bb);
    chk("zero_latency", 128'(lat), 128'd21);
    chk("zero_plaintext", plainText, 128'd0);
    tick();

    // Backpressure
    out_ready = 1'b0;
    send(C1_KEY, C1_CT);
    in_valid = 1'b0;
    wait_valid(1, lat, bb);
    chk("bp_latency", 128'(lat), 128'd21);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_pt", plainText, C1_PT);
      chk("bp_hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_released", 128'(out_valid), 128'd0);
    chk("bp_in_ready", 128'(in_ready), 128'd1);

    // in_valid held high with a different block while busy
    k2 = rnd128(); c2 = rnd128();
    send(C1_KEY, C1_CT);
    cipherKey = k2; cipherText = c2;
    wait_valid(1, lat, bb);
    chk("hold_latency", 128'(lat), 128'd21);
    chk("hold_plaintext", plainText, C1_PT);
    tick();
    chk("hold_second_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(1, lat, bb);
    chk("hold_second_latency", 128'(lat), 128'd21);
    chk("hold_second_pt", plainText, model_dec(k2, c2));
    tick();

    // Reset mid-ROUND
    send(C1_KEY, C1_CT);
    in_valid = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_plaintext", plainText, 128'd0);
    ov_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) ov_seen++;
      tick();
    end
    chk("abort_no_out", 128'(ov_seen), 128'd0);
    k2 = rnd128(); c2 = rnd128();
    send(k2, c2);
    in_valid = 1'b0;
    wait_valid(1, lat, bb);
    chk("abort_fresh_latency", 128'(lat), 128'd21);
    chk("abort_fresh_pt", plainText, model_dec(k2, c2));
    tick();

    // Back-to-back with in_valid high
    for (int i = 0; i < 3; i++) begin
      kk[i] = rnd128(); cc[i] = rnd128(); ee[i] = model_dec(kk[i], cc[i]);
    end
    idx = 0; outs = 0; t = 0;
    in_valid = 1'b1; cipherKey = kk[0]; cipherText = cc[0];
    while (outs < 3 && t < 100) begin
      acc = in_ready && in_valid;
      if (out_valid === 1'b1) begin
        chk("b2b_plaintext", plainText, ee[outs]);
        outs++;
      end
      tick();
      t++;
      if (acc) begin
        acc_cyc[idx] = t - 1;
        idx++;
        if (idx < 3) begin
          cipherKey = kk[idx]; cipherText = cc[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_outputs", 128'(outs), 128'd3);
    chk("b2b_accepts", 128'(idx), 128'd3);
    if (idx == 3) begin
      chk("b2b_spacing_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd22);
      chk("b2b_spacing_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd22);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
